// File: rtl/regfile_multiport_if.sv
// ============================================================================
//  regfile_multiport_if
//  Write-port and read-port bundle for regfile_multiport.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface regfile_multiport_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int NUM_READ      = 2,
    parameter int NUM_WRITE     = 1
);
    localparam int AW = $clog2(NUM_REGISTERS);

    logic [NUM_WRITE-1:0]            wr_en;
    logic [NUM_WRITE*AW-1:0]         wr_addr;
    logic [NUM_WRITE*DATA_WIDTH-1:0] wr_data;
    logic [NUM_READ-1:0]             rd_en;
    logic [NUM_READ*AW-1:0]          rd_addr;
    logic [NUM_READ*DATA_WIDTH-1:0]  rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data
    );
endinterface

`default_nettype wire

// File: rtl/regfile_multiport.sv
// ============================================================================
//  regfile_multiport
//  Multi-port register file: registered reads with hold, prioritised writes,
//  optional hardwired-zero x0. Define REGFILE_BYPASS_EN for write-first reads.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_multiport #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGISTERS = 32,
    parameter int NUM_READ      = 2,
    parameter int NUM_WRITE     = 1,
    parameter int ZERO_REG      = 1
) (
    input  logic                clk,
    input  logic                rst,
    regfile_multiport_if.slave  bus
);
    localparam int AW = $clog2(NUM_REGISTERS);

    logic [DATA_WIDTH-1:0]                regs_q [NUM_REGISTERS];
    logic [DATA_WIDTH-1:0]                regs_d [NUM_REGISTERS];
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_data_q;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_data_d;

    // Address is backed by storage and is not the hardwired-zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NUM_REGISTERS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Ascending port order lets the highest-index port overwrite earlier ones.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (bus.wr_en[w] && addr_ok(bus.wr_addr[w*AW +: AW])) begin
                regs_d[bus.wr_addr[w*AW +: AW]] = bus.wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // regs_d already holds the winning write, so it doubles as the bypass source.
    always_comb begin
        rd_data_d = rd_data_q;
        for (int r = 0; r < NUM_READ; r++) begin
            if (bus.rd_en[r]) begin
                if (!addr_ok(bus.rd_addr[r*AW +: AW])) begin
                    rd_data_d[r] = '0;
                end else begin
`ifdef REGFILE_BYPASS_EN
                    rd_data_d[r] = regs_d[bus.rd_addr[r*AW +: AW]];
`else
                    rd_data_d[r] = regs_q[bus.rd_addr[r*AW +: AW]];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            regs_q    <= regs_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_multiport.sv
// ============================================================================
//  tb_regfile_multiport
//  Two DUTs (ZERO_REG=1 with 20 regs, ZERO_REG=0 with 32 regs) on shared stimulus.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_multiport;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam int NW = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          t_rst;
    logic [NW-1:0] t_wr_en;
    logic [AW-1:0] t_wr_addr [NW];
    logic [DW-1:0] t_wr_data [NW];
    logic [NR-1:0] t_rd_en;
    logic [AW-1:0] t_rd_addr [NR];

    regfile_multiport_if #(.DATA_WIDTH(DW), .NUM_REGISTERS(20), .NUM_READ(NR), .NUM_WRITE(NW)) if_a ();
    regfile_multiport_if #(.DATA_WIDTH(DW), .NUM_REGISTERS(32), .NUM_READ(NR), .NUM_WRITE(NW)) if_b ();

    assign if_a.wr_en   = t_wr_en;
    assign if_a.wr_addr = {t_wr_addr[1], t_wr_addr[0]};
    assign if_a.wr_data = {t_wr_data[1], t_wr_data[0]};
    assign if_a.rd_en   = t_rd_en;
    assign if_a.rd_addr = {t_rd_addr[2], t_rd_addr[1], t_rd_addr[0]};
    assign if_b.wr_en   = t_wr_en;
    assign if_b.wr_addr = {t_wr_addr[1], t_wr_addr[0]};
    assign if_b.wr_data = {t_wr_data[1], t_wr_data[0]};
    assign if_b.rd_en   = t_rd_en;
    assign if_b.rd_addr = {t_rd_addr[2], t_rd_addr[1], t_rd_addr[0]};

    regfile_multiport #(.DATA_WIDTH(DW), .NUM_REGISTERS(20), .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(1))
        dut_a (.clk(clk), .rst(t_rst), .bus(if_a));
    regfile_multiport #(.DATA_WIDTH(DW), .NUM_REGISTERS(32), .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(0))
        dut_b (.clk(clk), .rst(t_rst), .bus(if_b));

    int checks   = 0;
    int failures = 0;
    logic chk_on = 1'b0;

    // Reference state: index 0 models dut_a, index 1 models dut_b.
    logic [DW-1:0] m_regs [2][32];
    logic [DW-1:0] m_exp  [2][NR];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rd_a(input int r);
        logic [NR*DW-1:0] v;
        v = if_a.rd_data;
        return v[r*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] rd_b(input int r);
        logic [NR*DW-1:0] v;
        v = if_b.rd_data;
        return v[r*DW +: DW];
    endfunction

    // What one rising edge does to a register file with nregs entries.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int  nregs;
            bit  zreg;
            nregs = (k == 0) ? 20 : 32;
            zreg  = (k == 0);
            if (t_rst) begin
                for (int i = 0; i < 32; i++) m_regs[k][i] = '0;
                for (int r = 0; r < NR; r++) m_exp[k][r] = '0;
            end else begin
                for (int r = 0; r < NR; r++) begin
                    if (t_rd_en[r]) begin
                        int a;
                        a = int'(t_rd_addr[r]);
                        if (a >= nregs || (zreg && a == 0)) begin
                            m_exp[k][r] = '0;
                        end else begin
                            m_exp[k][r] = m_regs[k][a];
`ifdef REGFILE_BYPASS_EN
                            for (int w = 0; w < NW; w++)
                                if (t_wr_en[w] && int'(t_wr_addr[w]) == a) m_exp[k][r] = t_wr_data[w];
`endif
                        end
                    end
                end
                for (int w = 0; w < NW; w++) begin
                    int a;
                    a = int'(t_wr_addr[w]);
                    if (t_wr_en[w] && a < nregs && !(zreg && a == 0)) m_regs[k][a] = t_wr_data[w];
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        t_rst   = 1'b0;
        t_wr_en = '0;
        t_rd_en = '0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        t_wr_en[p]   = 1'b1;
        t_wr_addr[p] = a;
        t_wr_data[p] = d;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        t_rd_en[p]   = 1'b1;
        t_rd_addr[p] = a;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int r = 0; r < NR; r++) begin
                check($sformatf("model_a_port%0d", r), rd_a(r), m_exp[0][r]);
                check($sformatf("model_b_port%0d", r), rd_b(r), m_exp[1][r]);
            end
        end
    end

    initial begin
        for (int w = 0; w < NW; w++) begin t_wr_addr[w] = '0; t_wr_data[w] = '0; end
        for (int r = 0; r < NR; r++) t_rd_addr[r] = '0;
        idle();
        t_rst = 1'b1;
        @(negedge clk);
        tick();
        tick();
        chk_on = 1'b1;
        for (int r = 0; r < NR; r++) check("reset_rd_a", rd_a(r), 32'h0);

        idle(); wr(0, 5'd7, 32'hDEADBEEF); tick();
        idle(); rd(0, 5'd7); rd(1, 5'd7); rd(2, 5'd7); tick();
        for (int r = 0; r < NR; r++) begin
            check("basic_x7_a", rd_a(r), 32'hDEADBEEF);
            check("basic_x7_b", rd_b(r), 32'hDEADBEEF);
        end

        idle(); wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22); tick();
        idle(); rd(0, 5'd3); tick();
        check("conflict_x3_a", rd_a(0), 32'h22);

        idle(); wr(0, 5'd0, 32'hFFFFFFFF); tick();
        idle(); rd(0, 5'd0); tick();
        check("zero_reg_a", rd_a(0), 32'h0);
        check("zero_reg_off_b", rd_b(0), 32'hFFFFFFFF);

        idle(); wr(0, 5'd9, 32'h1); tick();
        idle(); wr(1, 5'd9, 32'h2); rd(2, 5'd9); tick();
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_x9", rd_a(2), 32'h2);
`else
        check("same_cycle_x9", rd_a(2), 32'h1);
`endif
        idle(); rd(2, 5'd9); tick();
        check("after_write_x9", rd_a(2), 32'h2);

        idle(); wr(0, 5'd4, 32'hAA); tick();
        idle(); rd(1, 5'd4); tick();
        check("hold_first_x4", rd_a(1), 32'hAA);
        idle(); wr(0, 5'd4, 32'hBB); t_rd_addr[1] = 5'd5; tick();
        check("hold_kept_x4", rd_a(1), 32'hAA);
        idle(); rd(1, 5'd4); tick();
        check("hold_release_x4", rd_a(1), 32'hBB);

        idle(); wr(1, 5'd25, 32'h55); tick();
        idle(); rd(0, 5'd25); tick();
        check("oob_read_a", rd_a(0), 32'h0);
        check("inrange_25_b", rd_b(0), 32'h55);

        idle(); wr(0, 5'd5, 32'h77); tick();
        idle(); t_rst = 1'b1; wr(1, 5'd5, 32'h99); rd(0, 5'd5); rd(1, 5'd7); rd(2, 5'd4); tick();
        for (int r = 0; r < NR; r++) check("reset_dominates_b", rd_b(r), 32'h0);
        idle(); rd(0, 5'd5); tick();
        check("after_reset_x5", rd_b(0), 32'h0);

        for (int n = 0; n < 400; n++) begin
            idle();
            t_rst   = ($urandom_range(0, 49) == 0);
            t_wr_en = NW'($urandom());
            t_rd_en = NR'($urandom());
            for (int w = 0; w < NW; w++) begin
                t_wr_addr[w] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom());
                t_wr_data[w] = $urandom();
            end
            for (int r = 0; r < NR; r++)
                t_rd_addr[r] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom());
            tick();
        end

        idle(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
